// File: rtl/mpsoc_ahb3_mem_tester_if.sv
// AHB3-Lite bus bundle between the memory tester (master) and the slave under test.
// Master drives HSEL/HADDR/HWDATA/HWRITE/HSIZE/HBURST/HPROT/HTRANS/HMASTLOCK.
// Slave drives HRDATA/HREADY (its HREADYOUT)/HRESP.
interface mpsoc_ahb3_mem_tester_if #(
  parameter int PLEN = 32,
  parameter int XLEN = 32
);
  logic            HSEL;
  logic [PLEN-1:0] HADDR;
  logic [XLEN-1:0] HWDATA;
  logic            HWRITE;
  logic [2:0]      HSIZE;
  logic [2:0]      HBURST;
  logic [3:0]      HPROT;
  logic [1:0]      HTRANS;
  logic            HMASTLOCK;
  logic [XLEN-1:0] HRDATA;
  logic            HREADY;
  logic            HRESP;

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/mpsoc_ahb3_mem_tester.sv
// AHB3-Lite memory tester: writes Pattern(i) = SEED ^ addr(i) over WORDS words
// starting at BASE_ADDR, reads them back and compares.
// Ports:
//   HRESETn, HCLK   - async active-low reset, clock
//   start_i         - start request (honoured in IDLE/DONE only)
//   busy_o, done_o  - test running / finished (done held until next start)
//   pass_o          - no mismatches and no bus error (valid with done_o)
//   bus_err_o       - an HRESP error was seen
//   err_count_o     - saturating read mismatch count
//   fail_addr_o     - address of first mismatch or errored beat
//   ahb             - AHB3-Lite master port
module mpsoc_ahb3_mem_tester #(
  parameter int              PLEN      = 32,
  parameter int              XLEN      = 32,
  parameter logic [PLEN-1:0] BASE_ADDR = '0,
  parameter int              WORDS     = 256,
  parameter logic [31:0]     SEED      = 32'hA5A5_A5A5
) (
  input  logic                       HRESETn,
  input  logic                       HCLK,
  input  logic                       start_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       pass_o,
  output logic                       bus_err_o,
  output logic [15:0]                err_count_o,
  output logic [PLEN-1:0]            fail_addr_o,
  mpsoc_ahb3_mem_tester_if.master    ahb
);

  localparam logic [PLEN-1:0] STEP     = PLEN'(XLEN / 8);
  localparam logic [2:0]      SIZE     = (XLEN == 64) ? 3'b011 : 3'b010;
  localparam int              CW       = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0]   LAST     = CW'(WORDS - 1);
  localparam logic [1:0]      T_IDLE   = 2'b00;
  localparam logic [1:0]      T_NONSEQ = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  function automatic logic [XLEN-1:0] pattern(input logic [PLEN-1:0] a);
    return XLEN'(SEED) ^ XLEN'(a);
  endfunction

  state_t          state;
  logic [CW-1:0]   cnt;       // beat index of the address phase on the bus
  logic            hsel, hwrite;
  logic [1:0]      htrans;
  logic [PLEN-1:0] haddr;
  logic [XLEN-1:0] hwdata;
  // Data-phase tracker: the beat whose address phase was accepted last edge.
  logic            dp_vld, dp_wr;
  logic [PLEN-1:0] dp_addr;

  logic            mismatch, fail_latched;
  logic [15:0]     err_sat, err_next;

  assign mismatch     = dp_vld && !dp_wr && ahb.HREADY && !ahb.HRESP &&
                        (ahb.HRDATA != pattern(dp_addr));
  assign err_sat      = (err_count_o == 16'hFFFF) ? err_count_o : err_count_o + 16'd1;
  assign err_next     = mismatch ? err_sat : err_count_o;
  // Count saturates and never returns to zero, so it doubles as the latch flag.
  assign fail_latched = (err_count_o != 16'd0) || bus_err_o;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= S_IDLE;
      cnt         <= '0;
      hsel        <= 1'b0;
      hwrite      <= 1'b0;
      htrans      <= T_IDLE;
      haddr       <= '0;
      hwdata      <= '0;
      dp_vld      <= 1'b0;
      dp_wr       <= 1'b0;
      dp_addr     <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      bus_err_o   <= 1'b0;
      err_count_o <= '0;
      fail_addr_o <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state       <= S_WRITE;
            cnt         <= '0;
            hsel        <= 1'b1;
            hwrite      <= 1'b1;
            htrans      <= T_NONSEQ;
            haddr       <= BASE_ADDR;
            dp_vld      <= 1'b0;
            busy_o      <= 1'b1;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            bus_err_o   <= 1'b0;
            err_count_o <= '0;
            fail_addr_o <= '0;
          end
        end
        default: begin
          if (dp_vld && ahb.HRESP && !ahb.HREADY) begin
            // First cycle of a two-cycle error: drop the pending address
            // phase (never retried) and wait out the second cycle in DRAIN.
            bus_err_o <= 1'b1;
            if (!fail_latched) fail_addr_o <= dp_addr;
            hsel   <= 1'b0;
            htrans <= T_IDLE;
            state  <= S_DRAIN;
          end else if (ahb.HREADY) begin
            if (mismatch) begin
              err_count_o <= err_sat;
              if (!fail_latched) fail_addr_o <= dp_addr;
            end
            // Address phase on the bus moves into its data phase.
            dp_vld  <= htrans[1];
            dp_wr   <= hwrite;
            dp_addr <= haddr;
            if (htrans[1] && hwrite) hwdata <= pattern(haddr);
            case (state)
              S_WRITE: begin
                if (cnt == LAST) begin
                  state  <= S_READ;
                  cnt    <= '0;
                  haddr  <= BASE_ADDR;
                  hwrite <= 1'b0;
                end else begin
                  cnt   <= cnt + CW'(1);
                  haddr <= haddr + STEP;
                end
              end
              S_READ: begin
                if (cnt == LAST) begin
                  state  <= S_DRAIN;
                  hsel   <= 1'b0;
                  htrans <= T_IDLE;
                end else begin
                  cnt   <= cnt + CW'(1);
                  haddr <= haddr + STEP;
                end
              end
              S_DRAIN: begin
                state  <= S_DONE;
                dp_vld <= 1'b0;
                busy_o <= 1'b0;
                done_o <= 1'b1;
                pass_o <= !bus_err_o && (err_next == 16'd0);
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign ahb.HSEL      = hsel;
  assign ahb.HADDR     = haddr;
  assign ahb.HWDATA    = hwdata;
  assign ahb.HWRITE    = hwrite;
  assign ahb.HTRANS    = htrans;
  assign ahb.HSIZE     = SIZE;
  assign ahb.HBURST    = 3'b000;
  assign ahb.HPROT     = 4'b0011;
  assign ahb.HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_mpsoc_ahb3_mem_tester.sv
module tb_mpsoc_ahb3_mem_tester;
  localparam int          WORDS = 4;
  localparam logic [31:0] SEED  = 32'hA5A5_A5A5;
  localparam logic [31:0] NONE  = 32'hFFFF_FFF0;

  logic        HCLK, HRESETn, start_i;
  logic        busy_o, done_o, pass_o, bus_err_o;
  logic [15:0] err_count_o;
  logic [31:0] fail_addr_o;

  mpsoc_ahb3_mem_tester_if #(.PLEN(32), .XLEN(32)) bus ();

  mpsoc_ahb3_mem_tester #(.PLEN(32), .XLEN(32), .BASE_ADDR(32'h0), .WORDS(WORDS), .SEED(SEED)) dut (
    .HRESETn(HRESETn), .HCLK(HCLK), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .bus_err_o(bus_err_o),
    .err_count_o(err_count_o), .fail_addr_o(fail_addr_o), .ahb(bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] a);
    return SEED ^ a;
  endfunction

  // ---------------- slave: 16-word memory with fault knobs ----------------
  logic [31:0] wait_addr, corrupt_addr, err_addr;
  int          wait_n;
  logic [31:0] mem [16];
  logic        s_v, s_w;
  logic [31:0] s_a;
  int          wcnt, ecnt;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s_v <= 1'b0; s_w <= 1'b0; s_a <= '0; wcnt <= 0; ecnt <= 0;
    end else if (bus.HREADY) begin
      if (s_v && s_w) mem[s_a[5:2]] <= bus.HWDATA;
      s_v  <= bus.HSEL && bus.HTRANS == 2'b10;
      s_a  <= bus.HADDR;
      s_w  <= bus.HWRITE;
      wcnt <= (bus.HTRANS == 2'b10 && bus.HWRITE && bus.HADDR == wait_addr) ? wait_n : 0;
      ecnt <= (bus.HTRANS == 2'b10 && !bus.HWRITE && bus.HADDR == err_addr) ? 2 : 0;
    end else begin
      if (wcnt > 0) wcnt <= wcnt - 1;
      if (ecnt > 0) ecnt <= ecnt - 1;
    end
  end

  assign bus.HREADY = (ecnt != 2) && (wcnt == 0);
  assign bus.HRESP  = (ecnt != 0);
  assign bus.HRDATA = (s_v && !s_w) ? (mem[s_a[5:2]] ^ ((s_a == corrupt_addr) ? 32'h1 : 32'h0)) : '0;

  // ---------------- transaction-level model + scoreboard ----------------
  logic [32:0] expq[$];          // {write, addr} of beats still to be issued
  int          exp_err;
  logic [31:0] exp_fail;
  bit          exp_fail_set, exp_bus;
  bit          m_v, m_w, p_hold, p_w, p_done;
  logic [31:0] m_a, p_a;

  task automatic model_reset();
    expq.delete();
    for (int i = 0; i < WORDS; i++) expq.push_back({1'b1, 32'(i * 4)});
    for (int i = 0; i < WORDS; i++) expq.push_back({1'b0, 32'(i * 4)});
    exp_err = 0; exp_fail = '0; exp_fail_set = 0; exp_bus = 0;
  endtask

  initial begin
    logic [32:0] e;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        m_v = 0; p_hold = 0; p_done = 0;
        continue;
      end
      chk("const_ctl", {bus.HSIZE, bus.HBURST, bus.HPROT, bus.HMASTLOCK}, {3'b010, 3'b000, 4'b0011, 1'b0});
      chk("hsel", bus.HSEL, bus.HTRANS == 2'b10);
      if (p_hold) begin
        chk("hold_addr", bus.HADDR, p_a);
        chk("hold_trans", bus.HTRANS, 2'b10);
        chk("hold_write", bus.HWRITE, p_w);
      end
      if (m_v) begin
        if (m_w) chk("wdata", bus.HWDATA, pat(m_a));
        if (bus.HRESP && !bus.HREADY) begin
          exp_bus = 1;
          if (!exp_fail_set) begin exp_fail = m_a; exp_fail_set = 1; end
        end else if (bus.HREADY && !bus.HRESP && !m_w && bus.HRDATA != pat(m_a)) begin
          exp_err++;
          if (!exp_fail_set) begin exp_fail = m_a; exp_fail_set = 1; end
        end
        if (bus.HREADY) m_v = 0;
      end
      if (bus.HTRANS == 2'b10 && bus.HREADY) begin
        if (expq.size() == 0) begin
          checks++; failures++;
          $display("FAIL extra_beat act=addr %0h exp=no beat", bus.HADDR);
        end else begin
          e = expq.pop_front();
          chk("beat_addr", bus.HADDR, e[31:0]);
          chk("beat_write", bus.HWRITE, e[32]);
          m_v = 1; m_a = bus.HADDR; m_w = bus.HWRITE;
        end
      end
      if (done_o && !p_done) begin
        chk("st_err", err_count_o, (exp_err > 65535) ? 65535 : exp_err);
        chk("st_fail", fail_addr_o, exp_fail);
        chk("st_bus", bus_err_o, exp_bus);
        chk("st_pass", pass_o, exp_err == 0 && !exp_bus);
        chk("st_busy", busy_o, 1'b0);
      end
      p_done = done_o;
      p_hold = bus.HTRANS == 2'b10 && !bus.HREADY && !bus.HRESP;
      p_a    = bus.HADDR;
      p_w    = bus.HWRITE;
    end
  end

  // ---------------- directed runs ----------------
  logic [1:0]  sn_trans [64];
  logic [31:0] sn_addr  [64], sn_wdata [64], sn_fail [64];
  logic [15:0] sn_err   [64];
  logic        sn_busy  [64], sn_done [64], sn_bus [64];

  task automatic run(input logic [31:0] wa, input int wn, input logic [31:0] ca,
                     input logic [31:0] ea, input int sp, output int dc);
    wait_addr = wa; wait_n = wn; corrupt_addr = ca; err_addr = ea;
    model_reset();
    @(negedge HCLK); start_i = 1'b1;
    dc = -1;
    for (int c = 1; c < 64 && dc < 0; c++) begin
      @(negedge HCLK);
      start_i     = (c == sp);
      sn_trans[c] = bus.HTRANS; sn_addr[c] = bus.HADDR; sn_wdata[c] = bus.HWDATA;
      sn_busy[c]  = busy_o; sn_done[c] = done_o; sn_err[c] = err_count_o;
      sn_fail[c]  = fail_addr_o; sn_bus[c] = bus_err_o;
      if (done_o) dc = c;
    end
    start_i = 1'b0;
    if (dc < 0) begin
      checks++; failures++;
      $display("FAIL done_timeout act=no done exp=done within 63 cycles");
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_status"}, {busy_o, done_o, pass_o, bus_err_o, err_count_o}, '0);
    chk({tag, "_fail"}, fail_addr_o, 32'h0);
    chk({tag, "_bus"}, {bus.HSEL, bus.HWRITE, bus.HTRANS, bus.HADDR, bus.HWDATA}, '0);
  endtask

  int dc;

  initial begin
    HRESETn = 1'b0; start_i = 1'b0;
    wait_addr = NONE; corrupt_addr = NONE; err_addr = NONE; wait_n = 0;
    #12;
    check_reset("por");
    @(negedge HCLK); HRESETn = 1'b1;

    // 1: zero-wait pass
    run(NONE, 0, NONE, NONE, -1, dc);
    chk("t1_done_cyc", dc, 10);
    chk("t1_pass", {pass_o, bus_err_o, err_count_o}, {1'b1, 1'b0, 16'd0});
    chk("t1_c1", {sn_busy[1], sn_trans[1], sn_addr[1]}, {1'b1, 2'b10, 32'h0});
    chk("t1_c9_idle", sn_trans[9], 2'b00);
    chk("t1_mem0", mem[0], 32'hA5A5A5A5);
    chk("t1_mem1", mem[1], 32'hA5A5A5A1);
    chk("t1_mem2", mem[2], 32'hA5A5A5AD);
    chk("t1_mem3", mem[3], 32'hA5A5A5A9);
    chk("t1_left", expq.size(), 0);

    // 2: two wait states on write beat 1 data phase
    run(32'h4, 2, NONE, NONE, -1, dc);
    chk("t2_done_cyc", dc, 12);
    chk("t2_wdata_wait", {sn_wdata[3], sn_wdata[4], sn_wdata[5]}, {3{32'hA5A5A5A1}});
    chk("t2_addr_wait", {sn_addr[3], sn_addr[4], sn_addr[5]}, {3{32'h8}});
    chk("t2_pass", pass_o, 1'b1);

    // 3: corrupted read at address 8
    run(NONE, 0, 32'h8, NONE, -1, dc);
    chk("t3_done_cyc", dc, 10);
    chk("t3_status", {pass_o, bus_err_o, err_count_o, fail_addr_o}, {1'b0, 1'b0, 16'd1, 32'h8});

    // 4: error on read beat 1; also status cleared by start from failed DONE
    run(NONE, 0, NONE, 32'h4, -1, dc);
    chk("t4_cleared", {sn_done[1], sn_err[1], sn_fail[1], sn_busy[1]}, {1'b0, 16'd0, 32'h0, 1'b1});
    chk("t4_done_cyc", dc, 9);
    chk("t4_err_idle", sn_trans[8], 2'b00);
    chk("t4_status", {pass_o, bus_err_o, fail_addr_o}, {1'b0, 1'b1, 32'h4});
    chk("t4_left", expq.size(), 2);

    // 5: start pulsed during READ is ignored; rerun after fail passes
    run(NONE, 0, NONE, NONE, 6, dc);
    chk("t5_cleared", {sn_bus[1], sn_fail[1], sn_done[1]}, {1'b0, 32'h0, 1'b0});
    chk("t5_done_cyc", dc, 10);
    chk("t5_pass", {pass_o, err_count_o, bus_err_o}, {1'b1, 16'd0, 1'b0});

    // 6: async reset during write beat 2, then a clean rerun
    model_reset();
    @(negedge HCLK); start_i = 1'b1;
    @(negedge HCLK); start_i = 1'b0;
    @(negedge HCLK);
    @(negedge HCLK);
    chk("t6_pre", {bus.HTRANS, bus.HWRITE, bus.HADDR}, {2'b10, 1'b1, 32'h8});
    #2 HRESETn = 1'b0;
    #1 check_reset("midrst");
    @(negedge HCLK); HRESETn = 1'b1;
    run(NONE, 0, NONE, NONE, -1, dc);
    chk("t6_done_cyc", dc, 10);
    chk("t6_pass", pass_o, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
